// File: rtl/fq_multi.sv
// Multi-channel programmable clock divider: each channel emits a registered clock of
// period D and high time H, with double-buffered glitch-free reconfiguration and a global phase sync.
module fq_multi #(
  parameter int CNT_LEN = 8,
  parameter int N_CH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         load,
  input  logic [N_CH*CNT_LEN-1:0] div_in,
  input  logic [N_CH*CNT_LEN-1:0] high_in,
  input  logic                    sync,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         active,
  output logic [N_CH-1:0]         err
);

  localparam logic [CNT_LEN-1:0] ONE = CNT_LEN'(1);
  localparam logic [CNT_LEN-1:0] TWO = CNT_LEN'(2);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_LEN-1:0] act_d_reg, act_h_reg, pend_d_reg, pend_h_reg, p_reg;
    logic               pend_reg, run_reg, clk_reg, tick_reg;
    logic [CNT_LEN-1:0] ld_d, ld_h, eff_d, eff_h, new_d, new_h, new_h_cl, p_inc;
    logic               wrap;

    assign ld_d  = div_in[gi*CNT_LEN +: CNT_LEN];
    assign ld_h  = high_in[gi*CNT_LEN +: CNT_LEN];
    assign eff_d = pend_reg ? pend_d_reg : act_d_reg;
    assign eff_h = pend_reg ? pend_h_reg : act_h_reg;
    // A load landing on a boundary (start, wrap, sync) bypasses the pending stage.
    assign new_d = load[gi] ? ld_d : eff_d;
    assign new_h = load[gi] ? ld_h : eff_h;
    // Keep H inside [1, D-1] so a valid period always produces an edge.
    assign new_h_cl = (new_h == '0) ? ONE :
                      (new_h >= new_d) ? (new_d - ONE) : new_h;
    assign p_inc = p_reg + ONE;
    assign wrap  = (p_reg == act_d_reg - ONE);

    always_ff @(posedge clk) begin
      if (rst) begin
        act_d_reg  <= '0;
        act_h_reg  <= '0;
        pend_d_reg <= '0;
        pend_h_reg <= '0;
        pend_reg   <= 1'b0;
        p_reg      <= '0;
        run_reg    <= 1'b0;
        clk_reg    <= 1'b0;
        tick_reg   <= 1'b0;
      end else if (!run_reg) begin
        clk_reg  <= 1'b0;
        tick_reg <= 1'b0;
        p_reg    <= '0;
        if (en[gi] && new_d >= TWO) begin
          act_d_reg <= new_d;
          act_h_reg <= new_h_cl;
          pend_reg  <= 1'b0;
          run_reg   <= 1'b1;
          clk_reg   <= 1'b1;
          tick_reg  <= 1'b1;
        end else if (load[gi]) begin
          pend_d_reg <= ld_d;
          pend_h_reg <= ld_h;
          pend_reg   <= 1'b1;
        end
      end else if (wrap && !en[gi]) begin
        // Stop only at the end of a period; a coincident sync loses to it.
        run_reg  <= 1'b0;
        clk_reg  <= 1'b0;
        tick_reg <= 1'b0;
        p_reg    <= '0;
        if (load[gi]) begin
          pend_d_reg <= ld_d;
          pend_h_reg <= ld_h;
          pend_reg   <= 1'b1;
        end
      end else if (wrap || sync) begin
        act_d_reg <= new_d;
        act_h_reg <= new_h_cl;
        pend_reg  <= 1'b0;
        p_reg     <= '0;
        if (new_d < TWO) begin
          run_reg  <= 1'b0;
          clk_reg  <= 1'b0;
          tick_reg <= 1'b0;
        end else begin
          clk_reg  <= 1'b1;
          tick_reg <= 1'b1;
        end
      end else begin
        p_reg    <= p_inc;
        clk_reg  <= (p_inc < act_h_reg);
        tick_reg <= 1'b0;
        if (load[gi]) begin
          pend_d_reg <= ld_d;
          pend_h_reg <= ld_h;
          pend_reg   <= 1'b1;
        end
      end
    end

    assign clk_out[gi] = clk_reg;
    assign tick[gi]    = tick_reg;
    assign active[gi]  = run_reg;
    assign err[gi]     = (eff_d < TWO);
  end

endmodule

// File: tb/tb_fq_multi.sv
// Scoreboard bench for fq_multi: directed stimulus pushes hand-derived expected outputs,
// a negedge monitor pops and compares them once the corresponding clock edge has passed.
module tb_fq_multi;
  localparam int CNT_LEN = 8;
  localparam int N_CH    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_CH-1:0]         en, load, clk_out, tick, active, err;
  logic [N_CH*CNT_LEN-1:0] div_in, high_in;
  logic                    sync;

  fq_multi #(.CNT_LEN(CNT_LEN), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in), .high_in(high_in),
    .sync(sync), .clk_out(clk_out), .tick(tick), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] v;   // {clk_out, tick, active, err}
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {clk_out, tick, active, err};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL cyc%0d outputs {clk_out,tick,active,err}: got %b_%b_%b_%b want %b_%b_%b_%b",
                 e.cyc, got[7:6], got[5:4], got[3:2], got[1:0],
                 e.v[7:6], e.v[5:4], e.v[3:2], e.v[1:0]);
      end
    end
  end

  task automatic set_cfg(input int ch, input int d, input int h);
    div_in[ch*CNT_LEN +: CNT_LEN]  = CNT_LEN'(d);
    high_in[ch*CNT_LEN +: CNT_LEN] = CNT_LEN'(h);
  endtask

  // Character code per channel: 'T' = high with tick, '1' = high, '0' = low.
  task automatic expect_cyc(input byte c0, input byte c1, input logic [1:0] act_e,
                            input logic [1:0] err_e);
    exp_t e;
    logic [1:0] ck, tk;
    ck = {c1 != "0", c0 != "0"};
    tk = {c1 == "T", c0 == "T"};
    e.cyc = cyc_cnt + 1;
    e.v   = {ck, tk, act_e, err_e};
    q.push_back(e);
    $display("cyc%0d en=%b load=%b sync=%b rst=%b expect %b_%b_%b_%b",
             e.cyc, en, load, sync, rst, ck, tk, act_e, err_e);
    @(posedge clk);
    #1;
    load = '0;
    sync = 1'b0;
  endtask

  task automatic pat(input string s0, input string s1, input logic [1:0] act_e,
                     input logic [1:0] err_e);
    for (int i = 0; i < s0.len(); i++) expect_cyc(s0[i], s1[i], act_e, err_e);
  endtask

  initial begin
    rst = 1'b1; en = '0; load = '0; sync = 1'b0; div_in = '0; high_in = '0;
    // Reset state: everything low, err set because active D is zero.
    pat("00", "00", 2'b00, 2'b11);
    rst = 1'b0;
    pat("0", "0", 2'b00, 2'b11);

    // D=4 H=2 loaded into pending, then started.
    set_cfg(0, 4, 2); load = 2'b01;
    expect_cyc("0", "0", 2'b00, 2'b10);
    en = 2'b01;
    pat("T100T100", "00000000", 2'b01, 2'b10);

    // D=5 H=0 loaded on the wrap: immediate, H clamped to 1.
    set_cfg(0, 5, 0); load = 2'b01;
    pat("T0000T0000", "0000000000", 2'b01, 2'b10);
    pat("T", "0", 2'b01, 2'b10);
    // D=3 H=7 loaded mid-period: pending until the wrap, H clamped to 2.
    set_cfg(0, 3, 7); load = 2'b01;
    pat("0000", "0000", 2'b01, 2'b10);
    pat("T10T10T10", "000000000", 2'b01, 2'b10);

    // Back to 4/2 on the wrap, then 6/3 loaded at p=1 waits for the wrap.
    set_cfg(0, 4, 2); load = 2'b01;
    pat("T1", "00", 2'b01, 2'b10);
    set_cfg(0, 6, 3); load = 2'b01;
    pat("00", "00", 2'b01, 2'b10);
    pat("T11000T11000", "000000000000", 2'b01, 2'b10);
    // Same change coincident with the wrap takes effect at that boundary.
    set_cfg(0, 4, 2); load = 2'b01;
    pat("T100", "0000", 2'b01, 2'b10);
    set_cfg(0, 6, 3); load = 2'b01;
    pat("T11000", "000000", 2'b01, 2'b10);

    // en dropped at p=0: the period completes, then the channel idles.
    set_cfg(0, 4, 2); load = 2'b01;
    expect_cyc("T", "0", 2'b01, 2'b10);
    en = 2'b00;
    pat("100", "000", 2'b01, 2'b10);
    pat("000", "000", 2'b00, 2'b10);
    en = 2'b01;
    pat("T100T100", "00000000", 2'b01, 2'b10);

    // Ch0 D=3 H=1 on its wrap, ch1 D=5 H=2 started with a bypassing load.
    set_cfg(0, 3, 1); set_cfg(1, 5, 2); load = 2'b11; en = 2'b11;
    pat("T0", "T1", 2'b11, 2'b00);
    sync = 1'b1;
    pat("T00T00T00", "T1000T100", 2'b11, 2'b00);

    // Ch1 D=1 goes pending (err immediately), applied at its wrap: stops.
    set_cfg(1, 1, 0); load = 2'b10;
    expect_cyc("T", "0", 2'b11, 2'b10);
    expect_cyc("0", "0", 2'b01, 2'b10);
    pat("0T00T", "00000", 2'b01, 2'b10);
    // Idle with en=1 and an invalid load: stays idle.
    load = 2'b10;
    expect_cyc("0", "0", 2'b01, 2'b10);

    // Valid pending on ch0, then reset mid-run discards it.
    set_cfg(0, 6, 3); load = 2'b01;
    expect_cyc("0", "0", 2'b01, 2'b10);
    rst = 1'b1; en = 2'b00;
    expect_cyc("0", "0", 2'b00, 2'b11);
    rst = 1'b0;
    expect_cyc("0", "0", 2'b00, 2'b11);
    en = 2'b01;
    pat("00", "00", 2'b00, 2'b11);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
